// File: rtl/grey_bcd_pkg.sv
// Shared state type, widths and the Grey-to-binary helper for the
// three-digit Grey-coded decimal counter reader.
package grey_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DECODE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int cDIGIT_W = 5;
  localparam int cVALUE_W = 10;
  localparam logic [cDIGIT_W-1:0] cDIGIT_MAX = 5'd9;

  // Each binary bit is the XOR of all Grey bits at and above its position.
  function automatic logic [cDIGIT_W-1:0] grey5_to_bin(input logic [cDIGIT_W-1:0] grey);
    logic [cDIGIT_W-1:0] bin;
    bin[cDIGIT_W-1] = grey[cDIGIT_W-1];
    for (int i = cDIGIT_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ grey[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/grey5_dec.sv
// Combinational 5-bit Grey-to-binary converter with an out-of-range flag
// for decimal digits (anything above 9).
module grey5_dec
  import grey_bcd_pkg::*;
(
  input  logic [cDIGIT_W-1:0] grey,
  output logic [cDIGIT_W-1:0] bin,
  output logic                over
);

  // Convert and range-check one digit.
  always_comb begin
    bin  = grey5_to_bin(grey);
    over = (bin > cDIGIT_MAX);
  end

endmodule

// File: rtl/grey_bcd_reader.sv
// Reader for a three-digit Grey-coded decimal counter: synchronizes the digit
// buses, waits for a stable snapshot, then decodes and accumulates 0..999.
module grey_bcd_reader
  import grey_bcd_pkg::*;
#(
  parameter int pSTABLE  = 2,
  parameter int pTIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [cDIGIT_W-1:0] i_100,
  input  logic [cDIGIT_W-1:0] i_010,
  input  logic [cDIGIT_W-1:0] i_001,
  output logic                o_busy,
  output logic                o_valid,
  output logic [cVALUE_W-1:0] o_value,
  output logic                o_err,
  output logic [2:0]          o_digit_err
);

  localparam int cWORD_W = 3 * cDIGIT_W;
  localparam logic [3:0] cSTABLE  = 4'(pSTABLE);
  localparam logic [7:0] cTIMEOUT = 8'(pTIMEOUT);

  logic [cWORD_W-1:0]  sync1_r;
  logic [cWORD_W-1:0]  sync2_r;
  logic [cWORD_W-1:0]  sample_r;
  state_t              state_r;
  logic [3:0]          match_r;
  logic [7:0]          timeout_r;
  logic [1:0]          idx_r;
  logic [cVALUE_W-1:0] acc_r;
  logic [2:0]          derr_r;
  logic                abort_r;

  logic [3:0]          match_next_s;
  logic [7:0]          timeout_next_s;
  logic [cDIGIT_W-1:0] digit_grey_s;
  logic [cDIGIT_W-1:0] digit_bin_s;
  logic                digit_over_s;
  logic [cDIGIT_W-1:0] digit_sat_s;
  logic [cVALUE_W-1:0] acc_next_s;
  logic [2:0]          derr_next_s;

  // Free-running two-flop synchronizer for all fifteen digit bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= {i_100, i_010, i_001};
      sync2_r <= sync1_r;
    end
  end

  // Stability and timeout counters as they would be after this SAMPLE cycle.
  always_comb begin
    timeout_next_s = timeout_r + 8'd1;
    if ((sync2_r == sample_r) && (match_r != 4'd0)) begin
      match_next_s = match_r + 4'd1;
    end else begin
      match_next_s = 4'd1;
    end
  end

  // Select the digit under decode from the frozen snapshot, hundreds first.
  always_comb begin
    digit_grey_s = '0;
    case (idx_r)
      2'd2:    digit_grey_s = sample_r[3*cDIGIT_W-1:2*cDIGIT_W];
      2'd1:    digit_grey_s = sample_r[2*cDIGIT_W-1:cDIGIT_W];
      default: digit_grey_s = sample_r[cDIGIT_W-1:0];
    endcase
  end

  grey5_dec u_dec (
    .grey (digit_grey_s),
    .bin  (digit_bin_s),
    .over (digit_over_s)
  );

  // Saturate illegal digits to 9, flag them, and fold into acc*10 + digit.
  always_comb begin
    derr_next_s = derr_r;
    if (digit_over_s) begin
      digit_sat_s = cDIGIT_MAX;
      case (idx_r)
        2'd2:    derr_next_s[2] = 1'b1;
        2'd1:    derr_next_s[1] = 1'b1;
        default: derr_next_s[0] = 1'b1;
      endcase
    end else begin
      digit_sat_s = digit_bin_s;
    end
    acc_next_s = (acc_r << 3) + (acc_r << 1)
               + {{(cVALUE_W - cDIGIT_W){1'b0}}, digit_sat_s};
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      sample_r    <= '0;
      match_r     <= 4'd0;
      timeout_r   <= 8'd0;
      idx_r       <= 2'd0;
      acc_r       <= '0;
      derr_r      <= 3'd0;
      abort_r     <= 1'b0;
      o_busy      <= 1'b0;
      o_valid     <= 1'b0;
      o_value     <= '0;
      o_err       <= 1'b0;
      o_digit_err <= 3'd0;
    end else begin
      o_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            state_r   <= ST_SAMPLE;
            match_r   <= 4'd0;
            timeout_r <= 8'd0;
            idx_r     <= 2'd2;
            acc_r     <= '0;
            derr_r    <= 3'd0;
            abort_r   <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          timeout_r <= timeout_next_s;
          sample_r  <= sync2_r;
          match_r   <= match_next_s;
          // Stability takes priority over a coincident timeout.
          if (match_next_s == cSTABLE) begin
            state_r <= ST_DECODE;
          end else if (timeout_next_s == cTIMEOUT) begin
            state_r <= ST_DONE;
            abort_r <= 1'b1;
          end
        end
        ST_DECODE: begin
          acc_r  <= acc_next_s;
          derr_r <= derr_next_s;
          if (idx_r == 2'd0) begin
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r - 2'd1;
          end
        end
        ST_DONE: begin
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
          state_r <= ST_IDLE;
          if (abort_r) begin
            o_value     <= '0;
            o_err       <= 1'b1;
            o_digit_err <= 3'd0;
          end else begin
            o_value     <= acc_r;
            o_err       <= |derr_r;
            o_digit_err <= derr_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grey_bcd_reader.sv
// Scoreboard bench for grey_bcd_reader: stimulus pushes expectations from a
// decimal reference model, a negedge monitor pops them on every o_valid.
module tb_grey_bcd_reader;

  localparam int P_STABLE  = 2;
  localparam int P_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] d100;
  logic [4:0] d010;
  logic [4:0] d001;
  logic       busy;
  logic       valid;
  logic [9:0] value;
  logic       err;
  logic [2:0] derr;

  typedef struct {
    int value;
    int err;
    int derr;
    int start;
    int lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int valids = 0;
  int pushed = 0;

  grey_bcd_reader #(.pSTABLE(P_STABLE), .pTIMEOUT(P_TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_100       (d100),
    .i_010       (d010),
    .i_001       (d001),
    .o_busy      (busy),
    .o_valid     (valid),
    .o_value     (value),
    .o_err       (err),
    .o_digit_err (derr)
  );

  always #5 clk = ~clk;

  // Count active edges so latency is measured in clock cycles.
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int enc(input int n);
    return n ^ (n >> 1);
  endfunction

  // Inverse Grey by search, independent of any bitwise decode structure.
  function automatic int dec(input int g);
    for (int n = 0; n < 32; n++) begin
      if (enc(n) == g) return n;
    end
    return 0;
  endfunction

  function automatic exp_t model(input int gh, input int gt, input int go, input int st);
    int   d[3];
    exp_t x;
    d[0] = dec(gh);
    d[1] = dec(gt);
    d[2] = dec(go);
    x.derr = 0;
    for (int k = 0; k < 3; k++) begin
      if (d[k] > 9) begin
        x.derr = x.derr | (4 >> k);
        d[k] = 9;
      end
    end
    x.value = 100 * d[0] + 10 * d[1] + d[2];
    x.err   = (x.derr != 0) ? 1 : 0;
    x.start = st;
    x.lat   = P_STABLE + 4;
    return x;
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t x;
    if (valid) begin
      valids++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pulse with value %0d, expected none", value);
      end else begin
        x = sb.pop_front();
        check("value", int'(value), x.value);
        check("err", int'(err), x.err);
        check("digit_err", int'(derr), x.derr);
        check("latency", cyc - x.start, x.lat);
      end
    end
  end

  task automatic set_digits(input int gh, input int gt, input int go);
    @(negedge clk);
    d100 = 5'(gh);
    d010 = 5'(gt);
    d001 = 5'(go);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_exp(input exp_t x);
    sb.push_back(x);
    pushed++;
  endtask

  // mode 0: no result expected, 1: modelled result, 2: timeout abort.
  task automatic pulse_start(input int mode);
    exp_t x;
    @(negedge clk);
    start = 1'b1;
    if (mode == 1) begin
      push_exp(model(int'(d100), int'(d010), int'(d001), cyc + 1));
    end else if (mode == 2) begin
      x.value = 0;
      x.err   = 1;
      x.derr  = 0;
      x.start = cyc + 1;
      x.lat   = P_TIMEOUT + 1;
      push_exp(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got %0d pending results after %0d cycles, expected 0", sb.size(), n);
    end
    @(negedge clk);
  endtask

  initial begin
    int   busy_cnt;
    exp_t x;
    rst   = 1'b1;
    start = 1'b0;
    d100  = 5'd0;
    d010  = 5'd0;
    d001  = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_value", int'(value), 0);
    check("reset_err", int'(err), 0);
    check("reset_digit_err", int'(derr), 0);
    rst = 1'b0;

    // 537 with busy-length check.
    set_digits(enc(5), enc(3), enc(7));
    pulse_start(1);
    busy_cnt = int'(busy);
    repeat (6) begin
      @(negedge clk);
      busy_cnt += int'(busy);
    end
    check("busy_cycles", busy_cnt, P_STABLE + 4);
    wait_idle();

    // 999 then 000.
    set_digits(enc(9), enc(9), enc(9));
    pulse_start(1);
    wait_idle();
    set_digits(enc(0), enc(0), enc(0));
    pulse_start(1);
    wait_idle();

    // Tens digit decodes to 12: saturates to 9 and flags.
    set_digits(enc(0), enc(12), enc(5));
    pulse_start(1);
    wait_idle();

    // Reset during the second DECODE cycle aborts silently.
    set_digits(enc(5), enc(3), enc(7));
    pulse_start(0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_busy", int'(busy), 0);
    check("midreset_valid", int'(valid), 0);
    check("midreset_value", int'(value), 0);
    check("midreset_err", int'(err), 0);
    check("midreset_digit_err", int'(derr), 0);
    rst = 1'b0;
    set_digits(enc(1), enc(2), enc(3));
    pulse_start(1);
    wait_idle();

    // Ones digit never settles: timeout abort.
    d001 = 5'(enc(4));
    fork
      begin
        repeat (25) begin
          @(negedge clk);
          d001 = d001 ^ 5'b00001;
        end
      end
      begin
        repeat (3) @(negedge clk);
        pulse_start(2);
      end
    join
    wait_idle();

    // Start while busy is ignored.
    set_digits(enc(4), enc(0), enc(8));
    pulse_start(1);
    repeat (2) @(negedge clk);
    pulse_start(0);
    wait_idle();

    // Start held high re-triggers straight after DONE.
    set_digits(enc(2), enc(6), enc(1));
    @(negedge clk);
    start = 1'b1;
    push_exp(model(int'(d100), int'(d010), int'(d001), cyc + 1));
    x = model(int'(d100), int'(d010), int'(d001), cyc + 1 + P_STABLE + 5);
    push_exp(x);
    repeat (P_STABLE + 6) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Random digits, roughly a quarter drawn from the full 5-bit Grey space.
    for (int i = 0; i < 20; i++) begin
      int g[3];
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) g[k] = int'($urandom_range(0, 31));
        else g[k] = enc(int'($urandom_range(0, 9)));
      end
      set_digits(g[0], g[1], g[2]);
      pulse_start(1);
      wait_idle();
    end

    check("valid_count", valids, pushed);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
